pipe_ctrl: RTL and testbench

- Central stall/flush sequencer for the rv32 pipeline (IF, ID, EX, MEM, WB).
- Drives the per-stage register enables and bubble-inject flushes. Sources:
  - post-reset boot hold
  - load-use hazards
  - taken-branch/jump redirects from EX
  - data-memory req/ack handshake, with a timeout trap
- Sits beside the control decoder and drives the PC and all pipeline registers.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/pipe_ctrl_load_use_detect.sv | 30 +++
 rtl/pipe_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 pipeline types and constants
//
// Purpose : pipeline controller state encoding, register-address width and
//           the NOP instruction loaded by pipeline registers on a flush.
// Ports   : none (package).

package rv32_pkg;

   localparam int REG_ADDR_W = 5;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      TRAP     = 2'd3
   } pipe_state_t;

endpackage : rv32_pkg

// File: rtl/pipe_ctrl_load_use_detect.sv
// rtl/pipe_ctrl_load_use_detect.sv - combinational load-use hazard compare
//
// Purpose : flags an ID instruction that reads the destination of a load
//           currently in EX.
// Ports   : id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 - ID source operands
//           ex_rd, ex_mem_read                      - EX destination / is-load
//           hazard                                  - stall required

module load_use_detect
   import rv32_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign hazard = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule : load_use_detect

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - rv32 pipeline stall/flush sequencer
//
// Purpose : drives PC and pipeline-register enables plus bubble flushes from
//           boot hold, load-use hazards, EX redirects and the dmem handshake,
//           trapping when dmem fails to acknowledge in time.
// Ports   : clk, rst (async, active low)
//           id_*/ex_rd/ex_mem_read  - hazard inputs
//           ex_br_taken             - EX redirect
//           mem_req/dmem_ack        - data-memory handshake
//           pc_en .. mem_wb_en      - stage enables
//           if_id_flush/id_ex_flush - bubble inject
//           trap, state, stall_count - status / debug

module pipe_ctrl
   import rv32_pkg::*;
#(
   parameter int BOOT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5,
   parameter int PERF_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_br_taken,
   input  logic                  mem_req,
   input  logic                  dmem_ack,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  trap,
   output logic [1:0]            state,
   output logic [PERF_W-1:0]     stall_count
);

   localparam logic [1:0] S_BOOT     = BOOT;
   localparam logic [1:0] S_RUN      = RUN;
   localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
   localparam logic [1:0] S_TRAP     = TRAP;

   localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [PERF_W-1:0] PERF_MAX  = '1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              trap_q, trap_d;
   logic [PERF_W-1:0] stall_q;
   logic              hazard;
   logic              ack_eff;
   logic              run_adv;
   logic              stall_inc;

   load_use_detect u_load_use_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .hazard      (hazard)
   );

   // A MEM instruction dropping its request without an ack is treated as
   // completed so the pipeline cannot wedge on an illegal handshake.
   assign ack_eff = dmem_ack || !mem_req;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      trap_d      = trap_q;
      run_adv     = 1'b0;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;

      case (state_q)
         S_BOOT: begin
            // PC held while the front stages fill with bubbles
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if (cnt_q == BOOT_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (mem_req && !dmem_ack) begin
               // first frozen cycle counts toward the timeout
               state_d = S_MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end else begin
               run_adv = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (ack_eff) begin
               run_adv = 1'b1;
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == TO_LAST) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
               end
            end
         end
         default: begin
            trap_d = 1'b1;
         end
      endcase

      // Normal advance: redirect outranks load-use since ID is squashed anyway
      if (run_adv) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end

      // Outputs are quiet for the whole time reset is held, not just after an edge
      if (!rst) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_en    = 1'b0;
         ex_mem_en   = 1'b0;
         mem_wb_en   = 1'b0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
      end
   end

   assign stall_inc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_BOOT;
         cnt_q   <= '0;
         trap_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         if (stall_inc && (stall_q != PERF_MAX)) begin
            stall_q <= stall_q + 1'b1;
         end
      end
   end

   assign trap        = trap_q;
   assign state       = state_q;
   assign stall_count = stall_q;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
   logic        mem_req, dmem_ack;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, trap;
   logic [1:0]  state;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;

   pipe_ctrl #(
      .BOOT_CYCLES (4),
      .MEM_TIMEOUT (16),
      .CNT_W       (5),
      .PERF_W      (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .ex_br_taken (ex_br_taken),
      .mem_req     (mem_req),
      .dmem_ack    (dmem_ack),
      .pc_en       (pc_en),
      .if_id_en    (if_id_en),
      .id_ex_en    (id_ex_en),
      .ex_mem_en   (ex_mem_en),
      .mem_wb_en   (mem_wb_en),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .trap        (trap),
      .state       (state),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // en order: {pc, if_id, id_ex, ex_mem, mem_wb}; fl order: {if_id, id_ex}
   task automatic chk_out(input string tag, input logic [4:0] en, input logic [1:0] fl);
      chk({tag, ".en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, en});
      chk({tag, ".fl"}, {30'd0, if_id_flush, id_ex_flush}, {30'd0, fl});
   endtask

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_br_taken = 1'b0;
      mem_req = 1'b0; dmem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();

      // reset state
      #3;
      chk_out("rst", 5'b00000, 2'b00);
      chk("rst.state", state, 0);
      chk("rst.trap", trap, 0);
      chk("rst.stall", stall_count, 0);

      // boot hold: exactly four bubble cycles
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_out($sformatf("boot%0d", i), 5'b01111, 2'b11);
         chk($sformatf("boot%0d.state", i), state, 0);
         @(negedge clk);
      end
      #1;
      chk("run.state", state, 1);
      chk_out("run", 5'b11111, 2'b00);
      chk("run.stall", stall_count, 0);

      // load-use on rs2
      @(negedge clk);
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      #1;
      chk_out("lu_rs2", 5'b00111, 2'b01);
      @(negedge clk);
      #1;
      chk("lu_rs2.stall", stall_count, 1);

      // load to x0 is never a hazard
      ex_rd = 5'd0; id_rs2 = 5'd0;
      #1;
      chk_out("lu_x0", 5'b11111, 2'b00);
      @(negedge clk);
      #1;
      chk("lu_x0.stall", stall_count, 1);

      // redirect squashes the load-use
      ex_rd = 5'd5; id_rs2 = 5'd5; ex_br_taken = 1'b1;
      #1;
      chk_out("br", 5'b11111, 2'b11);
      @(negedge clk);
      #1;
      chk("br.stall", stall_count, 1);

      // load-use on rs1
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      #1;
      chk_out("lu_rs1", 5'b00111, 2'b01);
      @(negedge clk);
      #1;
      chk("lu_rs1.stall", stall_count, 2);

      // matching address but operand unused
      id_uses_rs1 = 1'b0;
      #1;
      chk_out("lu_unused", 5'b11111, 2'b00);

      // matching address but EX is not a load
      id_uses_rs1 = 1'b1; ex_mem_read = 1'b0;
      #1;
      chk_out("lu_noload", 5'b11111, 2'b00);

      // req and ack together: no stall
      clear_inputs();
      mem_req = 1'b1; dmem_ack = 1'b1;
      #1;
      chk_out("mem_fast", 5'b11111, 2'b00);
      @(negedge clk);
      #1;
      chk("mem_fast.state", state, 1);

      // three frozen cycles then ack
      dmem_ack = 1'b0;
      #1;
      chk_out("mw0", 5'b00000, 2'b00);
      chk("mw0.state", state, 1);
      @(negedge clk);
      #1;
      chk_out("mw1", 5'b00000, 2'b00);
      chk("mw1.state", state, 2);
      @(negedge clk);
      #1;
      chk_out("mw2", 5'b00000, 2'b00);
      chk("mw2.state", state, 2);
      @(negedge clk);
      dmem_ack = 1'b1;
      #1;
      chk_out("mw_ack", 5'b11111, 2'b00);
      chk("mw_ack.state", state, 2);
      @(negedge clk);
      mem_req = 1'b0; dmem_ack = 1'b0;
      #1;
      chk("mw_done.state", state, 1);
      chk("mw_done.stall", stall_count, 5);

      // dmem timeout: 16 frozen cycles then trap
      @(negedge clk);
      mem_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("to%0d.pc_en", i), pc_en, 0);
         chk($sformatf("to%0d.state", i), state, (i == 0) ? 1 : 2);
         chk($sformatf("to%0d.trap", i), trap, 0);
         @(negedge clk);
      end
      #1;
      chk("trap.state", state, 3);
      chk("trap.trap", trap, 1);
      chk_out("trap", 5'b00000, 2'b00);
      chk("trap.stall", stall_count, 21);

      // trap is sticky even if dmem finally answers
      mem_req = 1'b0; dmem_ack = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("trap_hold.state", state, 3);
      chk("trap_hold.trap", trap, 1);
      chk_out("trap_hold", 5'b00000, 2'b00);
      chk("trap_hold.stall", stall_count, 21);

      // only reset clears the trap
      rst = 1'b0;
      #1;
      chk("trap_rst.state", state, 0);
      chk("trap_rst.trap", trap, 0);
      chk("trap_rst.stall", stall_count, 0);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("reboot.state", state, 1);

      // async reset in the middle of MEM_WAIT
      @(negedge clk);
      mem_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("amw.state", state, 2);
      chk("amw.stall", stall_count, 2);
      #1;
      rst = 1'b0;
      #1;
      chk("arst.state", state, 0);
      chk("arst.stall", stall_count, 0);
      chk_out("arst", 5'b00000, 2'b00);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("reboot2.state", state, 1);

      // continuous load-use stall saturates the counter
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      repeat (65540) @(negedge clk);
      #1;
      chk("sat.stall", stall_count, 32'h0000_FFFF);
      chk("sat.pc_en", pc_en, 0);
      @(negedge clk);
      #1;
      chk("sat2.stall", stall_count, 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pipe_ctrl
